// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg -- shared definitions for the pong score/serve control slice.
//
// Contents:
//   score_state_t  : score controller FSM states (IDLE, PLAY, PAUSE, GAME_OVER)
//   XPOS_W         : width of the ball x position bus
//   SCORE_W        : width of each player's score
//   CENTER_X       : x position splitting the field between the two players
//   WINNER_*       : encodings driven on the winner output
//   credit_point() : saturating score increment
// ---------------------------------------------------------------------------
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        PAUSE     = 2'd2,
        GAME_OVER = 2'd3
    } score_state_t;

    localparam int XPOS_W  = 11;
    localparam int SCORE_W = 4;

    localparam logic [XPOS_W-1:0] CENTER_X = 11'd512;

    localparam logic [1:0] WINNER_NONE   = 2'b00;
    localparam logic [1:0] WINNER_FIRST  = 2'b01;
    localparam logic [1:0] WINNER_SECOND = 2'b10;

    // Adds one point but never moves a score beyond the winning limit.
    function automatic logic [SCORE_W-1:0] credit_point(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] limit
    );
        return (score < limit) ? score + 4'd1 : limit;
    endfunction

endpackage

// File: rtl/score_ctl_if.sv
// ---------------------------------------------------------------------------
// score_ctl_if -- groups the signals between ball_ctl/user input and score_ctl.
//
// Signals:
//   score_flag            one-cycle pulse, ball left the field
//   xpos                  ball x position, valid with score_flag
//   start_btn             synchronised, debounced start/restart button
//   points_first_player   first-player score
//   points_second_player  second-player score
//   serve_hold            high while the ball is frozen at serve position
//   game_over             high while the game is over
//   winner                00 none, 01 first player, 10 second player
//
// Modports:
//   master : the environment side (drives inputs, observes results)
//   slave  : score_ctl itself
// ---------------------------------------------------------------------------
interface score_ctl_if;
    import pong_pkg::*;

    logic               score_flag;
    logic [XPOS_W-1:0]  xpos;
    logic               start_btn;
    logic [SCORE_W-1:0] points_first_player;
    logic [SCORE_W-1:0] points_second_player;
    logic               serve_hold;
    logic               game_over;
    logic [1:0]         winner;

    modport master (
        output score_flag,
        output xpos,
        output start_btn,
        input  points_first_player,
        input  points_second_player,
        input  serve_hold,
        input  game_over,
        input  winner
    );

    modport slave (
        input  score_flag,
        input  xpos,
        input  start_btn,
        output points_first_player,
        output points_second_player,
        output serve_hold,
        output game_over,
        output winner
    );

endinterface

// File: rtl/pause_timer.sv
// ---------------------------------------------------------------------------
// pause_timer -- down-counter timing the serve pause.
//
// Parameters:
//   PAUSE_CYCLES  length of the pause in clk cycles (minimum 2)
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset, clears the counter
//   load  reloads the counter with PAUSE_CYCLES-1 (wins over en)
//   en    decrements the counter while it is non-zero
//   done  high while the counter is at zero
// ---------------------------------------------------------------------------
module pause_timer #(
    parameter int PAUSE_CYCLES = 65_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic done
);

    // PAUSE_CYCLES-1 always fits in clog2(PAUSE_CYCLES) bits.
    localparam int                CNT_W    = $clog2(PAUSE_CYCLES);
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(PAUSE_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Counter register: load on pause entry, then count down to zero and stop
    // there so done stays asserted until the next load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= LOAD_VAL;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/score_ctl.sv
// ---------------------------------------------------------------------------
// score_ctl -- pong score keeping and serve/game-over control.
//
// Parameters:
//   WIN_POINTS    score that ends the game (1..15)
//   PAUSE_CYCLES  serve pause length in clk cycles (minimum 2)
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-low reset
//   bus  score_ctl_if.slave: score_flag/xpos/start_btn in,
//        points, serve_hold, game_over, winner out (all registered)
// ---------------------------------------------------------------------------
module score_ctl
    import pong_pkg::*;
#(
    parameter int WIN_POINTS   = 10,
    parameter int PAUSE_CYCLES = 65_000_000
) (
    input  logic        clk,
    input  logic        rst,
    score_ctl_if.slave  bus
);

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_POINTS);

    score_state_t       state_q, state_d;
    logic [SCORE_W-1:0] first_q, first_d;
    logic [SCORE_W-1:0] second_q, second_d;
    logic [1:0]         winner_q, winner_d;
    logic               serve_hold_q, serve_hold_d;
    logic               game_over_q, game_over_d;
    logic               start_btn_q;
    logic               start_edge;
    logic               timer_load;
    logic               timer_en;
    logic               timer_done;

    // A held button produces a single edge because start_btn_q follows it.
    assign start_edge = bus.start_btn & ~start_btn_q;

    // The timer is reloaded on the cycle the FSM moves into PAUSE and only
    // counts while the FSM sits in PAUSE.
    assign timer_load = (state_d == PAUSE) && (state_q != PAUSE);
    assign timer_en   = (state_q == PAUSE);

    pause_timer #(
        .PAUSE_CYCLES (PAUSE_CYCLES)
    ) u_pause_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .en   (timer_en),
        .done (timer_done)
    );

    // Next-state and next-output logic. Scores and winner change together
    // with the state so that every output lands in the same register update.
    // serve_hold and game_over are derived from the next state so they are
    // registered alongside it rather than decoded from state_q.
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        second_d = second_q;
        winner_d = winner_q;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = PAUSE;
                end
            end

            PAUSE: begin
                if (timer_done) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
                if (bus.score_flag) begin
                    if (bus.xpos < CENTER_X) begin
                        second_d = credit_point(second_q, WIN_SCORE);
                        if (second_d == WIN_SCORE) begin
                            state_d  = GAME_OVER;
                            winner_d = WINNER_SECOND;
                        end else begin
                            state_d = PAUSE;
                        end
                    end else begin
                        first_d = credit_point(first_q, WIN_SCORE);
                        if (first_d == WIN_SCORE) begin
                            state_d  = GAME_OVER;
                            winner_d = WINNER_FIRST;
                        end else begin
                            state_d = PAUSE;
                        end
                    end
                end
            end

            GAME_OVER: begin
                if (start_edge) begin
                    state_d  = PAUSE;
                    first_d  = '0;
                    second_d = '0;
                    winner_d = WINNER_NONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        serve_hold_d = (state_d != PLAY);
        game_over_d  = (state_d == GAME_OVER);
    end

    // State and output registers, plus the button history used for edge
    // detection. Reset returns to a fresh IDLE with nothing carried over.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            first_q      <= '0;
            second_q     <= '0;
            winner_q     <= WINNER_NONE;
            serve_hold_q <= 1'b1;
            game_over_q  <= 1'b0;
            start_btn_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            second_q     <= second_d;
            winner_q     <= winner_d;
            serve_hold_q <= serve_hold_d;
            game_over_q  <= game_over_d;
            start_btn_q  <= bus.start_btn;
        end
    end

    assign bus.points_first_player  = first_q;
    assign bus.points_second_player = second_q;
    assign bus.serve_hold           = serve_hold_q;
    assign bus.game_over            = game_over_q;
    assign bus.winner               = winner_q;

endmodule

// File: doc/score_ctl.md
SCORE_CTL -- requirements
Module: score_ctl

Interface
REQ-001 Parameter WIN_POINTS, default 10 (legal 1..15): score that ends the game.
REQ-002 Parameter PAUSE_CYCLES, default 65_000_000 (1 s at 65 MHz): serve pause length in clk cycles, minimum 2.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 score_flag  input  1  one-cycle pulse from ball_ctl: ball left the field.
REQ-006 xpos  input  11  ball x position from ball_ctl, sampled with score_flag.
REQ-007 start_btn  input  1  start/restart request, already synchronised and debounced.
REQ-008 points_first_player  output  4  first-player score, fed to ball_ctl.
REQ-009 points_second_player  output  4  second-player score, fed to ball_ctl.
REQ-010 serve_hold  output  1  high = ball frozen at serve position.
REQ-011 game_over  output  1  high while in GAME_OVER.
REQ-012 winner  output  2  00 none, 01 first player, 10 second player.

Function
REQ-013 FSM states: IDLE, PLAY, PAUSE, GAME_OVER; all outputs registered.
REQ-014 start edge = start_btn & ~start_btn_q (registered previous value); a held button gives exactly one edge.
REQ-015 IDLE: serve_hold=1, points 0, winner 00; start edge -> PAUSE.
REQ-016 PLAY: serve_hold=0; score_flag with xpos < CENTER_X (512) credits second player, xpos >= 512 credits first player.
REQ-017 Credited score updates in the cycle after score_flag is sampled (latency 1); the other score is unchanged.
REQ-018 After a credit: new score == WIN_POINTS -> GAME_OVER, else -> PAUSE, in the same cycle as the score update.
REQ-019 score_flag is ignored in IDLE, PAUSE and GAME_OVER; a credit never increments a score past WIN_POINTS.
REQ-020 PAUSE: serve_hold=1; down-counter loaded with PAUSE_CYCLES-1 on entry; state -> PLAY on the cycle after the counter reaches 0, giving exactly PAUSE_CYCLES cycles of serve_hold.
REQ-021 GAME_OVER: game_over=1, serve_hold=1, winner set to the scoring player and held.
REQ-022 GAME_OVER + start edge: both points cleared to 0, winner 00, game_over 0 in the next cycle -> PAUSE.
REQ-023 start edges in PLAY and PAUSE are ignored.
REQ-024 score_flag and start edge in the same cycle: the state's own rule applies (PLAY credits the point; GAME_OVER restarts).

Reset
REQ-025 rst low at a clock edge forces IDLE, points 0, winner 00, game_over 0, serve_hold 1, pause counter 0, start_btn_q 0.
REQ-026 Reset mid-PAUSE or mid-PLAY discards scores and timer; nothing is carried over.

Structure
REQ-027 Shared package pong_pkg holds the state enum score_state_t, CENTER_X=512 and the winner encodings.
REQ-028 The pause counter is a sub-module pause_timer (inputs load and en, output done, parameter PAUSE_CYCLES); the FSM and scores live in score_ctl.

Verification (PAUSE_CYCLES=4, WIN_POINTS=3)
REQ-029 Reset, start pulse -> IDLE, PAUSE for exactly 4 cycles with serve_hold=1, then PLAY with serve_hold=0.
REQ-030 PLAY, score_flag with xpos=0 -> next cycle points_second_player=1, points_first_player=0, state PAUSE.
REQ-031 PLAY, score_flag with xpos=1023 three times (each after its pause) -> points_first_player=3, game_over=1, winner=01.
REQ-032 score_flag pulsed during PAUSE and during GAME_OVER -> scores unchanged.
REQ-033 GAME_OVER, start_btn held high for 10 cycles -> one restart only: points 0/0, winner 00, PAUSE then PLAY.
REQ-034 rst low for one cycle during PAUSE with scores 2/1 -> IDLE, points 0/0, serve_hold=1.
